// File: rtl/regfile_pkg.sv
// regfile_pkg: definitions shared by the register-file write-port controller.
//   - Default address/data widths and register count.
//   - The holding-buffer state enum.
package regfile_pkg;

    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned NREGS_DEF = 32;

    // EMPTY: buffer free, multdiv results accepted. HELD: one result waiting.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } wr_state_e;

endpackage

// File: rtl/regfile_wr_ctrl_dec.sv
// reg_onehot_dec: combinational register-address to one-hot enable decoder.
//   en     in   decode enable; all outputs low when clear
//   addr   in   register address
//   onehot out  one-hot enable vector; bit 0 always low (register 0 is hardwired zero)
module reg_onehot_dec #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             en,
    input  logic [AW-1:0]    addr,
    output logic [NREGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            onehot[i] = en && (addr == AW'(i));
        end
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: register-file write-port controller.
// Arbitrates pipeline writeback (P) against late multdiv results (M) with a
// one-entry holding buffer (H). Priority P > H > M; one registered write per cycle.
//   clk, clr          clock (rising edge), asynchronous active-high clear
//   p_valid/addr/data pipeline writeback, never back-pressured
//   m_valid/addr/data multdiv result; m_ready accepts when the buffer is empty
//   wr_en, wr_data    registered one-hot register enables and write data
//   pend_valid/addr   holding-buffer occupancy and destination (0 when empty)
//   stall_req         held result has waited MAXHOLD cycles behind pipeline writes
module regfile_wr_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned MAXHOLD = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             p_valid,
    input  logic [AW-1:0]    p_addr,
    input  logic [DW-1:0]    p_data,
    input  logic             m_valid,
    input  logic [AW-1:0]    m_addr,
    input  logic [DW-1:0]    m_data,
    output logic             m_ready,
    output logic [NREGS-1:0] wr_en,
    output logic [DW-1:0]    wr_data,
    output logic             pend_valid,
    output logic [AW-1:0]    pend_addr,
    output logic             stall_req
);

    localparam int unsigned CW = $clog2(MAXHOLD + 1);

    wr_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    buf_addr_q, buf_addr_d;
    logic [DW-1:0]    buf_data_q, buf_data_d;
    logic             stall_q, stall_d;
    logic [NREGS-1:0] wr_en_q;
    logic [DW-1:0]    wr_data_q;

    logic             p_act, held, m_acc, m_live;
    logic             sel_en;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic [NREGS-1:0] dec_out;

    assign held   = (state_q == ST_HELD);
    assign p_act  = p_valid && (p_addr != '0);
    assign m_acc  = m_valid && (state_q == ST_EMPTY);
    // A result for register 0 completes its handshake but is dropped here.
    assign m_live = m_acc && (m_addr != '0);

    // State register plus the data it carries.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_EMPTY;
            cnt_q      <= '0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            stall_q    <= 1'b0;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            stall_q    <= stall_d;
            wr_en_q    <= dec_out;
            wr_data_q  <= sel_data;
        end
    end

    // Next-state and write selection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        sel_en     = 1'b0;
        sel_addr   = '0;
        sel_data   = '0;

        if (p_act) begin
            sel_en   = 1'b1;
            sel_addr = p_addr;
            sel_data = p_data;
            if (held) begin
                // A held result to the same register is older than P: drop it.
                if (buf_addr_q == p_addr) begin
                    state_d = ST_EMPTY;
                    cnt_d   = '0;
                end else if (cnt_q != CW'(MAXHOLD)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (m_live && (m_addr != p_addr)) begin
                state_d    = ST_HELD;
                cnt_d      = '0;
                buf_addr_d = m_addr;
                buf_data_d = m_data;
            end
        end else if (held) begin
            sel_en   = 1'b1;
            sel_addr = buf_addr_q;
            sel_data = buf_data_q;
            state_d  = ST_EMPTY;
            cnt_d    = '0;
        end else if (m_live) begin
            sel_en   = 1'b1;
            sel_addr = m_addr;
            sel_data = m_data;
        end

        // Computed from next state so stall_req lines up with pend_valid.
        stall_d = (state_d == ST_HELD) && (cnt_d == CW'(MAXHOLD));
    end

    reg_onehot_dec #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_dec (
        .en     (sel_en),
        .addr   (sel_addr),
        .onehot (dec_out)
    );

    // Outputs come from flops only; no input-to-output path.
    always_comb begin
        m_ready    = (state_q == ST_EMPTY);
        pend_valid = held;
        pend_addr  = held ? buf_addr_q : '0;
        stall_req  = stall_q;
        wr_en      = wr_en_q;
        wr_data    = wr_data_q;
    end

endmodule

// File: doc/regfile_wr_ctrl.md
# regfile_wr_ctrl

Write-port controller for the processor register file built from enabled, async-clear flip-flops. It arbitrates between the in-order pipeline writeback and the late multiply/divide result. Each cycle it produces one registered write, as a one-hot register enable plus data. A single-entry holding buffer absorbs collisions, and a pending-address output lets decode stall on the held destination.

## Interface
- NREGS, 32, number of architectural registers; register 0 is hardwired zero
- AW, 5, register address width; NREGS = 2**AW
- DW, 32, data width
- MAXHOLD, 4, cycles a held result may wait before stall_req asserts
- clk  in  1  clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- p_valid  in  1  pipeline writeback valid; never back-pressured
- p_addr  in  AW  pipeline destination register
- p_data  in  DW  pipeline write data
- m_valid  in  1  multdiv result valid
- m_addr  in  AW  multdiv destination register
- m_data  in  DW  multdiv result
- m_ready  out  1  buffer can accept a multdiv result; a transfer occurs when m_valid && m_ready
- wr_en  out  NREGS  one-hot register enables, registered; bit 0 never set
- wr_data  out  DW  write data, registered
- pend_valid  out  1  holding buffer occupied
- pend_addr  out  AW  destination register of the held result
- stall_req  out  1  request for the pipeline to insert a writeback bubble

## Operation
- States: EMPTY and HELD. m_ready = (state == EMPTY), driven from the state flop only, with no input-to-output combinational path.
- Source candidates at each edge:
  - P = p_valid && p_addr != 0.
  - H = state HELD.
  - M = m_valid && m_ready.
- Arbitration priority is P > H > M. Exactly one write is selected per edge, or none.
- EMPTY:
  - P and M: write P; M is loaded into the buffer; go to HELD.
  - M only: write M; stay in EMPTY.
  - P only: write P.
- HELD:
  - P present: write P; the buffer holds and the hold counter increments.
  - No P: write the buffer contents; go to EMPTY.
- Same-address rule: if P wins and the held or incoming M result targets p_addr, that result is discarded (treated as older) and the buffer returns to or stays EMPTY.
- Address 0:
  - A P with p_addr == 0 counts as no P.
  - An M with m_addr == 0 is accepted (handshake completes) and discarded.
- Hold counter:
  - Resets to 0 on entering HELD.
  - Saturates at MAXHOLD.
  - stall_req = HELD && counter == MAXHOLD, registered.
  - If p_valid stays high regardless, P still wins; there is no deadlock guarantee beyond the request.
- pend_valid and pend_addr reflect the buffer; pend_addr is 0 when the buffer is empty.

## Timing
- Latency: a source sampled at edge k drives wr_en/wr_data during cycle k..k+1; the register file captures at edge k+1.
- A write reaching the register file at edge k+1 is not visible through pend_* after edge k.
- clr (asynchronous, immediate) sets:
  - wr_en = 0, wr_data = 0.
  - state EMPTY, so m_ready = 1.
  - pend_valid = 0, pend_addr = 0.
  - counter = 0, stall_req = 0.
- clr mid-operation drops the held result and any in-flight write.
- Back-to-back multdiv results are accepted every cycle while P is idle. At most one result is buffered; m_ready falls the cycle after a buffer load.

## Structure
- Shared package `regfile_pkg`: the state enum (ST_EMPTY, ST_HELD) and the AW/DW/NREGS defaults.
- One sub-module, `reg_onehot_dec`:
  - Combinational address-to-one-hot decoder with an enable input.
  - Forces bit 0 low.
  - Its output feeds the wr_en output register.

## Test plan
- Reset: assert clr mid-HELD → next cycle all outputs 0, m_ready = 1, no write of the held value.
- P only, p_addr = 5, p_data = 0xDEADBEEF → wr_en = 1<<5 and wr_data = 0xDEADBEEF one cycle later.
- P (addr 3, 0x11) with M (addr 7, 0x22) in the same cycle:
  - Next cycle writes reg 3; pend_valid = 1, pend_addr = 7, m_ready = 0.
  - With P idle, the following cycle writes reg 7 = 0x22 and pend_valid drops.
- Same-address discard: M (addr 9) held, then P to addr 9 with 0x55 → reg 9 written with 0x55, buffer emptied, and 0x22-style stale data is never written.
- Starvation: buffer held with P valid for MAXHOLD = 4 consecutive cycles → stall_req = 1; dropping p_valid → held write issues and stall_req clears.
- Address 0: P with addr 0 plus M with addr 0 → no wr_en bit set, M handshake completes, pend_valid stays 0.
